// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache:
// address field layout, line/word types, controller state encoding.
package cache_pkg;

    localparam int ADDR_W = 32;
    localparam int LINES  = 4;
    localparam int WORDS  = 8;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 2;
    localparam int OFF_W  = 3;
    localparam int TAG_W  = ADDR_W - 7;
    localparam int LINE_W = WORDS * DATA_W;

    typedef logic [TAG_W-1:0]              tag_t;
    typedef logic [IDX_W-1:0]              idx_t;
    typedef logic [OFF_W-1:0]              off_t;
    typedef logic [DATA_W-1:0]             word_t;
    typedef logic [WORDS-1:0][DATA_W-1:0]  line_t;

    // Byte address split into its cache fields, MSB first.
    typedef struct packed {
        tag_t       tag;
        idx_t       idx;
        off_t       off;
        logic [1:0] byte_off;
    } addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic addr_t split_addr(input logic [ADDR_W-1:0] a);
        return addr_t'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(input tag_t t, input idx_t i, input off_t o);
        return {t, i, o, 2'b00};
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side buses of the cache. On the CPU bus the CPU is
// master; on the memory bus the cache is master.
interface cache_cpu_if;
    import cache_pkg::*;

    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                cpu_stall;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    input  cpu_rdata, cpu_stall);
    modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    output cpu_rdata, cpu_stall);
endinterface

interface cache_mem_if;
    import cache_pkg::*;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/cache_line_store.sv
// Line storage for the cache: data array, tags, valid and dirty bits.
// A refill beat has priority over a CPU store; the controller never issues both.
module cache_line_store
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_en,
    input  idx_t                   st_idx,
    input  off_t                   st_off,
    input  word_t                  st_data,
    input  logic                   fill_en,
    input  idx_t                   fill_idx,
    input  off_t                   fill_off,
    input  word_t                  fill_data,
    input  logic                   fill_last,
    input  tag_t                   fill_tag,
    input  logic                   clean_en,
    input  idx_t                   clean_idx,
    output line_t [LINES-1:0]      lines_o,
    output tag_t  [LINES-1:0]      tags_o,
    output logic  [LINES-1:0]      valid_o,
    output logic  [LINES-1:0]      dirty_o
);

    line_t [LINES-1:0] data_q, data_d;
    tag_t  [LINES-1:0] tag_q,  tag_d;
    logic  [LINES-1:0] valid_q, valid_d;
    logic  [LINES-1:0] dirty_q, dirty_d;

    // Next-state of the arrays from the fill and store write ports.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            data_d[fill_idx][fill_off] = fill_data;
        end else if (st_en) begin
            data_d[st_idx][st_off] = st_data;
            dirty_d[st_idx]        = 1'b1;
        end else begin
            data_d = data_q;
        end
        // Last refill beat publishes the line; end of write-back marks it clean.
        if (fill_en && fill_last) begin
            tag_d[fill_idx]   = fill_tag;
            valid_d[fill_idx] = 1'b1;
            dirty_d[fill_idx] = 1'b0;
        end else if (clean_en) begin
            dirty_d[clean_idx] = 1'b0;
        end else begin
            tag_d = tag_q;
        end
    end

    // Array registers; reset wipes every line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            tag_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    assign lines_o = data_q;
    assign tags_o  = tag_q;
    assign valid_o = valid_q;
    assign dirty_o = dirty_q;

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller: hit path,
// miss FSM (write-back, refill, replay) and word-wide memory beat interface.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_cpu_if.slave         cpu,
    cache_mem_if.master        mem,
    output logic [LINE_W-1:0]  line_dbg0,
    output logic [LINE_W-1:0]  line_dbg1,
    output logic [LINE_W-1:0]  line_dbg2,
    output logic [LINE_W-1:0]  line_dbg3,
    output logic [LINES-1:0]   valid_dbg,
    output logic [LINES-1:0]   dirty_dbg
);

    addr_t             req_addr_s;
    logic [1:0]        addr_unused_s;
    line_t [LINES-1:0] lines_s;
    tag_t  [LINES-1:0] tags_s;
    logic  [LINES-1:0] valid_s;
    logic  [LINES-1:0] dirty_s;
    logic              hit_s;

    state_e state_q, state_d;
    off_t   beat_q, beat_d;
    tag_t   miss_tag_q, miss_tag_d;
    tag_t   old_tag_q, old_tag_d;
    idx_t   miss_idx_q, miss_idx_d;

    logic               stall_s;
    logic               mem_req_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    word_t              mem_wdata_s;
    logic               st_en_s;
    logic               fill_en_s;
    logic               fill_last_s;
    logic               clean_en_s;

    assign req_addr_s    = split_addr(cpu.cpu_addr);
    assign addr_unused_s = req_addr_s.byte_off;
    assign hit_s         = valid_s[req_addr_s.idx] && (tags_s[req_addr_s.idx] == req_addr_s.tag);

    // FSM next state, beat counter and memory/store strobes.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        miss_tag_d  = miss_tag_q;
        old_tag_d   = old_tag_q;
        miss_idx_d  = miss_idx_q;
        stall_s     = 1'b1;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        st_en_s     = 1'b0;
        fill_en_s   = 1'b0;
        fill_last_s = 1'b0;
        clean_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu.cpu_req && hit_s) begin
                    stall_s = 1'b0;
                    st_en_s = cpu.cpu_we;
                end else if (cpu.cpu_req) begin
                    // Capture both tags now so the write-back address cannot drift.
                    miss_tag_d = req_addr_s.tag;
                    old_tag_d  = tags_s[req_addr_s.idx];
                    miss_idx_d = req_addr_s.idx;
                    beat_d     = 3'd0;
                    state_d    = (valid_s[req_addr_s.idx] && dirty_s[req_addr_s.idx]) ? ST_WB : ST_FILL;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_WB: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = beat_addr(old_tag_q, miss_idx_q, beat_q);
                mem_wdata_s = lines_s[miss_idx_q][beat_q];
                if (mem.mem_ack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        clean_en_s = 1'b1;
                        state_d    = ST_FILL;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_FILL: begin
                mem_req_s  = 1'b1;
                mem_addr_s = beat_addr(miss_tag_q, miss_idx_q, beat_q);
                if (mem.mem_ack) begin
                    fill_en_s   = 1'b1;
                    fill_last_s = (beat_q == 3'd7);
                    beat_d      = beat_q + 3'd1;
                    state_d     = (beat_q == 3'd7) ? ST_DONE : ST_FILL;
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= 3'd0;
            miss_tag_q <= '0;
            old_tag_q  <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            miss_tag_q <= miss_tag_d;
            old_tag_q  <= old_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    cache_line_store u_store (
        .clk       (clk),
        .rst       (rst),
        .st_en     (st_en_s),
        .st_idx    (req_addr_s.idx),
        .st_off    (req_addr_s.off),
        .st_data   (cpu.cpu_wdata),
        .fill_en   (fill_en_s),
        .fill_idx  (miss_idx_q),
        .fill_off  (beat_q),
        .fill_data (mem.mem_rdata),
        .fill_last (fill_last_s),
        .fill_tag  (miss_tag_q),
        .clean_en  (clean_en_s),
        .clean_idx (miss_idx_q),
        .lines_o   (lines_s),
        .tags_o    (tags_s),
        .valid_o   (valid_s),
        .dirty_o   (dirty_s)
    );

    assign cpu.cpu_rdata = lines_s[req_addr_s.idx][req_addr_s.off];
    assign cpu.cpu_stall = stall_s;
    assign mem.mem_req   = mem_req_s;
    assign mem.mem_we    = mem_we_s;
    assign mem.mem_addr  = mem_addr_s;
    assign mem.mem_wdata = mem_wdata_s;

    assign line_dbg0 = lines_s[0];
    assign line_dbg1 = lines_s[1];
    assign line_dbg2 = lines_s[2];
    assign line_dbg3 = lines_s[3];
    assign valid_dbg = valid_s;
    assign dirty_dbg = dirty_s;

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl against an array-based cache
// and memory model; the bench plays the memory with random ack latency.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_cpu_if cif ();
    cache_mem_if mif ();

    logic [255:0] dbg0, dbg1, dbg2, dbg3;
    logic [3:0]   valid_dbg, dirty_dbg;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cif),
        .mem       (mif),
        .line_dbg0 (dbg0),
        .line_dbg1 (dbg1),
        .line_dbg2 (dbg2),
        .line_dbg3 (dbg3),
        .valid_dbg (valid_dbg),
        .dirty_dbg (dirty_dbg)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: cache contents and backing memory.
    logic [31:0] m_data [4][8];
    logic [24:0] m_tag  [4];
    bit          m_valid[4];
    bit          m_dirty[4];
    logic [31:0] mem_model [logic [31:0]];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;
    beat_t obs_q[$];
    beat_t exp_q[$];

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
    endfunction

    function automatic logic [255:0] model_line(input int i);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = m_data[i][k];
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tag[i] = '0; m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
            for (int k = 0; k < 8; k++) m_data[i][k] = '0;
        end
    endtask

    task automatic check_state();
        logic [3:0] v, d;
        for (int i = 0; i < 4; i++) begin v[i] = m_valid[i]; d[i] = m_dirty[i]; end
        check_eq("valid_dbg", valid_dbg, v);
        check_eq("dirty_dbg", dirty_dbg, d);
        check_eq("line_dbg0", dbg0, model_line(0));
        check_eq("line_dbg1", dbg1, model_line(1));
        check_eq("line_dbg2", dbg2, model_line(2));
        check_eq("line_dbg3", dbg3, model_line(3));
    endtask

    // Drive one CPU access and act as memory until it completes (or is aborted by reset).
    task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input int abort_at, output logic [31:0] rdata,
                             output int stall_cyc, output int mem_cyc, output bit aborted);
        bit          new_beat = 1'b1;
        int          delay = 0;
        int          fill_acks = 0;
        logic [31:0] b_addr = '0;
        logic [31:0] b_data = '0;
        logic        b_we = 1'b0;
        stall_cyc = 0; mem_cyc = 0; aborted = 1'b0; rdata = '0;
        cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = addr; cif.cpu_wdata = wdata;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            mif.mem_ack = 1'b0;
            if (!cif.cpu_stall) begin
                rdata = cif.cpu_rdata;
                @(posedge clk); #1;
                cif.cpu_req = 1'b0; cif.cpu_we = 1'b0;
                return;
            end
            stall_cyc++;
            if (mif.mem_req) begin
                mem_cyc++;
                if (!mif.mem_we && abort_at >= 0 && fill_acks == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_eq("abort_mem_req", mif.mem_req, 1'b0);
                    check_eq("abort_valid", valid_dbg, 4'h0);
                    check_eq("abort_dirty", dirty_dbg, 4'h0);
                    check_eq("abort_lines", dbg0 | dbg1 | dbg2 | dbg3, 256'd0);
                    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                if (new_beat) begin
                    b_addr = mif.mem_addr; b_we = mif.mem_we; b_data = mif.mem_wdata;
                    delay = $urandom_range(0, 3);
                    new_beat = 1'b0;
                end else begin
                    check_eq("mem_addr_stable", mif.mem_addr, b_addr);
                    check_eq("mem_we_stable", mif.mem_we, b_we);
                    if (b_we) check_eq("mem_wdata_stable", mif.mem_wdata, b_data);
                end
                if (delay == 0) begin
                    mif.mem_ack = 1'b1;
                    if (b_we) begin
                        mem_model[b_addr] = mif.mem_wdata;
                        obs_q.push_back(beat_t'({1'b1, b_addr, mif.mem_wdata}));
                    end else begin
                        mif.mem_rdata = mem_rd(b_addr);
                        obs_q.push_back(beat_t'({1'b0, b_addr, mif.mem_rdata}));
                        fill_acks++;
                    end
                    new_beat = 1'b1;
                end else begin
                    delay--;
                end
            end
            @(posedge clk);
        end
        check_eq("access_timeout", 1'b1, 1'b0);
        mif.mem_ack = 1'b0;
        cif.cpu_req = 1'b0; cif.cpu_we = 1'b0;
        @(posedge clk); #1;
    endtask

    // One access checked against the model: hit latency, beat trace, data and debug views.
    task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input int abort_at);
        logic [1:0]  idx = addr[6:5];
        logic [2:0]  off = addr[4:2];
        logic [24:0] tg  = addr[31:7];
        logic [2:0]  kk;
        logic [31:0] rdata, ea;
        int          stall_cyc, mem_cyc, n;
        bit          aborted;
        bit          hit = m_valid[idx] && (m_tag[idx] == tg);
        obs_q.delete(); exp_q.delete();
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx])
                for (int k = 0; k < 8; k++) begin
                    kk = 3'(k);
                    exp_q.push_back(beat_t'({1'b1, m_tag[idx], idx, kk, 2'b00, m_data[idx][k]}));
                end
            for (int k = 0; k < 8; k++) begin
                kk = 3'(k);
                ea = {tg, idx, kk, 2'b00};
                exp_q.push_back(beat_t'({1'b0, ea, mem_rd(ea)}));
            end
        end
        do_access(addr, we, wdata, abort_at, rdata, stall_cyc, mem_cyc, aborted);
        if (aborted) begin
            model_reset();
            check_state();
            return;
        end
        if (hit) begin
            check_eq("hit_stall_cycles", stall_cyc, 0);
            check_eq("hit_mem_cycles", mem_cyc, 0);
        end else begin
            check_eq("miss_beat_count", obs_q.size(), exp_q.size());
            n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
            for (int i = 0; i < n; i++) begin
                check_eq("beat_we", obs_q[i].we, exp_q[i].we);
                check_eq("beat_addr", obs_q[i].addr, exp_q[i].addr);
                if (exp_q[i].we) check_eq("beat_wdata", obs_q[i].data, exp_q[i].data);
            end
            check_eq("miss_stall_cycles", stall_cyc, mem_cyc + 2);
            for (int k = 0; k < 8; k++) m_data[idx][k] = mem_rd({tg, idx, 3'(k), 2'b00});
            m_tag[idx] = tg; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_data[idx][off] = wdata;
            m_dirty[idx] = 1'b1;
        end else begin
            check_eq("cpu_rdata", rdata, m_data[idx][off]);
        end
        check_state();
    endtask

    initial begin
        rst = 1'b1;
        cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = '0; cif.cpu_wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        model_reset();
        for (int k = 0; k < 8; k++) mem_model[32'h40 + 32'(4*k)] = 32'h1000 + 32'(k);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_cpu_stall", cif.cpu_stall, 1'b0);
        check_eq("rst_cpu_rdata", cif.cpu_rdata, 32'h0);
        check_eq("rst_mem_req", mif.mem_req, 1'b0);
        check_eq("rst_mem_we", mif.mem_we, 1'b0);
        check_eq("rst_mem_addr", mif.mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mif.mem_wdata, 32'h0);
        check_state();
        @(posedge clk); #1;

        // Directed: refill, store hit, load hit, dirty eviction.
        run_access(32'h0000_0040, 1'b0, 32'h0, -1);
        check_eq("first_fill_valid", valid_dbg, 4'b0100);
        run_access(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, -1);
        check_eq("store_word1_line2", dbg2[63:32], 32'hDEAD_BEEF);
        check_eq("store_dirty", dirty_dbg, 4'b0100);
        run_access(32'h0000_0044, 1'b0, 32'h0, -1);
        run_access(32'h0000_00C4, 1'b0, 32'h0, -1);
        check_eq("evict_wb_word1", mem_rd(32'h44), 32'hDEAD_BEEF);
        check_eq("evict_dirty", dirty_dbg, 4'b0000);

        // Reset during refill beat 4, then the same load refills again.
        run_access(32'h0000_0040, 1'b0, 32'h0, 4);
        run_access(32'h0000_0040, 1'b0, 32'h0, -1);

        // Fill and dirty all four lines.
        for (int i = 0; i < 4; i++) run_access(32'(32 * i), 1'b0, 32'h0, -1);
        for (int i = 0; i < 4; i++) run_access(32'(32 * i + 4 * i), 1'b1, 32'hA500_0000 + 32'(i), -1);
        check_eq("all_valid", valid_dbg, 4'hF);
        check_eq("all_dirty", dirty_dbg, 4'hF);

        // Random traffic over eight tags, with stray acks while the bus is idle.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mif.mem_ack = 1'b1; mif.mem_rdata = $urandom;
                @(posedge clk); #1;
                mif.mem_ack = 1'b0;
                check_state();
            end
            run_access(32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)), $urandom, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
